xbar_arbiter: RTL and testbench
===============================

XBAR_ARBITER -- requirements
Module: xbar_arbiter

Interface
REQ-001 Parameter S_DATA_COUNT, default 2, number of source (master) streams; SHALL be >= 2.
REQ-002 Parameter M_DATA_COUNT, default 3, number of destination (slave) ports; SHALL be >= 2.
REQ-003 Localparam T_DEST_WIDTH = $clog2(M_DATA_COUNT), width of each destination field.
REQ-004 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_i  input  1  reset; synchronous, active-high.
REQ-006 s_dest_i  input  [T_DEST_WIDTH-1:0] x S_DATA_COUNT  destination port requested by each source; stable for a whole packet.
REQ-007 s_valid_i  input  S_DATA_COUNT  per-source beat valid.
REQ-008 s_last_i  input  S_DATA_COUNT  per-source last-beat-of-packet flag.
REQ-009 s_ready_o  output  S_DATA_COUNT  per-source ready, returned from the granted destination.
REQ-010 m_ready_i  input  M_DATA_COUNT  per-destination ready.
REQ-011 req_o  output  [S_DATA_COUNT-1:0] x M_DATA_COUNT  grant matrix; req_o[m][s]=1 routes source s to destination m; drives the crossbar's req_i directly.
REQ-012 busy_o  output  M_DATA_COUNT  destination m currently holds a grant.

Function
REQ-013 Each destination m SHALL run an independent two-state FSM: IDLE, BUSY.
REQ-014 Source s requests m when s_valid_i[s]=1, s_dest_i[s]==m and s holds no grant on any destination.
REQ-015 IDLE: if one or more requests for m exist, select one by round-robin, register req_o[m] one-hot on it, enter BUSY; grant visible one cycle after the request (1-cycle arbitration latency).
REQ-016 Round-robin: search sources starting at rr_ptr[m], ascending, wrapping S_DATA_COUNT-1 -> 0; first requester wins.
REQ-017 BUSY: req_o[m] SHALL be held unchanged regardless of s_valid_i changes (valid may drop mid-packet).
REQ-018 Release: in BUSY, when granted source g has s_valid_i[g] & m_ready_i[m] & s_last_i[g] in the same cycle, next state IDLE, req_o[m] cleared, rr_ptr[m] <= (g+1) mod S_DATA_COUNT.
REQ-019 No same-cycle re-grant: after release, destination m SHALL spend at least one cycle in IDLE (one-cycle bubble between packets).
REQ-020 s_ready_o[s] = OR over m of (req_o[m][s] & m_ready_i[m]); combinational from registered grants; 0 for ungranted sources.
REQ-021 A source SHALL be granted to at most one destination at a time; a column of req_o SHALL be one-hot or zero per destination and each source bit set in at most one row.
REQ-022 s_dest_i[s] >= M_DATA_COUNT: request ignored, never granted, s_ready_o[s]=0.
REQ-023 Simultaneous IDLE arbitration on different destinations by different sources SHALL both grant in the same cycle.
REQ-024 Single-beat packet (s_last_i with first beat): grant, one handshake, release per REQ-018.
REQ-025 busy_o[m] = (state[m]==BUSY).
REQ-026 Requests arriving while m is BUSY SHALL wait; no starvation: every persistent requester granted within S_DATA_COUNT packets on that destination.

Reset
REQ-027 On rst_i=1 at a clock edge: all FSMs IDLE, req_o all 0, busy_o 0, rr_ptr all 0; consequently s_ready_o 0.
REQ-028 Reset asserted mid-packet SHALL abort the grant at that edge; no release pointer update; arbitration resumes the first cycle after rst_i deasserts.

Verification
REQ-029 Reset, then s0 valid dest=1 -> cycle+1 req_o[1]=2'b01, busy_o=3'b010, s_ready_o[0]=m_ready_i[1].
REQ-030 s0,s1 both valid dest=2, rr_ptr=0, 3-beat packets, m_ready_i=1 -> s0 granted first; after s0 last, 1 IDLE cycle, s1 granted; rr_ptr[2]=0 after s1 release.
REQ-031 s0 dest=0 and s1 dest=2 same cycle -> next cycle req_o[0]=01, req_o[2]=10, both busy.
REQ-032 s0 granted on dest 1, s0 valid drops for 3 cycles, m_ready_i toggles -> req_o[1] held 01; release only on valid&ready&last.
REQ-033 s1 dest=3 (M=3) -> never granted, s_ready_o[1]=0 indefinitely.
REQ-034 rst_i pulsed mid-packet on dest 0 -> next cycle req_o all 0, s_ready_o 0, rr_ptr[0]=0.

Source files
------------

// File: rtl/xbar_arbiter.sv
// Per-destination packet arbiter for a crossbar: each destination port grants one
// source at a time by round-robin and holds the grant until that source's last beat.
module xbar_arbiter #(
   parameter int S_DATA_COUNT = 2,
   parameter int M_DATA_COUNT = 3,
   localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0]   s_dest_i,
   input  logic [S_DATA_COUNT-1:0]                s_valid_i,
   input  logic [S_DATA_COUNT-1:0]                s_last_i,
   output logic [S_DATA_COUNT-1:0]                s_ready_o,
   input  logic [M_DATA_COUNT-1:0]                m_ready_i,
   output logic [M_DATA_COUNT*S_DATA_COUNT-1:0]   req_o,
   output logic [M_DATA_COUNT-1:0]                busy_o
);

   localparam int PW = (S_DATA_COUNT > 2) ? $clog2(S_DATA_COUNT) : 1;

   // busy_o mirrors state_q one bit per destination, so it doubles as the FSM state view.
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t                  state_q  [M_DATA_COUNT];
   logic [S_DATA_COUNT-1:0] grant_q  [M_DATA_COUNT];
   logic [PW-1:0]           gidx_q   [M_DATA_COUNT];
   logic [PW-1:0]           rr_ptr_q [M_DATA_COUNT];

   logic [S_DATA_COUNT-1:0] has_grant;
   logic [S_DATA_COUNT-1:0] req_m    [M_DATA_COUNT];
   logic [PW-1:0]           pick_idx [M_DATA_COUNT];
   logic [M_DATA_COUNT-1:0] release_m;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
      int t;
      t = int'(base) + off;
      if (t >= S_DATA_COUNT) t = t - S_DATA_COUNT;
      return PW'(t);
   endfunction

   always_comb begin
      for (int s = 0; s < S_DATA_COUNT; s++) begin
         has_grant[s] = 1'b0;
         for (int m = 0; m < M_DATA_COUNT; m++) begin
            has_grant[s] = has_grant[s] | grant_q[m][s];
         end
      end
      for (int m = 0; m < M_DATA_COUNT; m++) begin
         req_m[m] = '0;
         for (int s = 0; s < S_DATA_COUNT; s++) begin
            // Out-of-range destinations never match any m, so they are never granted.
            if (s_valid_i[s] && !has_grant[s] &&
                s_dest_i[s*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(m))
               req_m[m][s] = 1'b1;
         end
      end
      // Walk offsets high to low so the requester nearest rr_ptr overwrites the rest.
      for (int m = 0; m < M_DATA_COUNT; m++) begin
         pick_idx[m] = rr_ptr_q[m];
         for (int i = S_DATA_COUNT - 1; i >= 0; i--) begin
            if (req_m[m][wrap_add(rr_ptr_q[m], i)])
               pick_idx[m] = wrap_add(rr_ptr_q[m], i);
         end
      end
      for (int m = 0; m < M_DATA_COUNT; m++) begin
         release_m[m] = (state_q[m] == BUSY) && s_valid_i[gidx_q[m]] &&
                        m_ready_i[m] && s_last_i[gidx_q[m]];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int m = 0; m < M_DATA_COUNT; m++) begin
            state_q[m]  <= IDLE;
            grant_q[m]  <= '0;
            gidx_q[m]   <= '0;
            rr_ptr_q[m] <= '0;
         end
      end else begin
         for (int m = 0; m < M_DATA_COUNT; m++) begin
            case (state_q[m])
               IDLE: begin
                  if (|req_m[m]) begin
                     grant_q[m] <= S_DATA_COUNT'(1) << pick_idx[m];
                     gidx_q[m]  <= pick_idx[m];
                     state_q[m] <= BUSY;
                  end
               end
               BUSY: begin
                  if (release_m[m]) begin
                     grant_q[m]  <= '0;
                     rr_ptr_q[m] <= wrap_add(gidx_q[m], 1);
                     state_q[m]  <= IDLE;
                  end
               end
               default: state_q[m] <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      s_ready_o = '0;
      for (int m = 0; m < M_DATA_COUNT; m++) begin
         req_o[m*S_DATA_COUNT +: S_DATA_COUNT] = grant_q[m];
         busy_o[m] = (state_q[m] == BUSY);
         for (int s = 0; s < S_DATA_COUNT; s++) begin
            s_ready_o[s] = s_ready_o[s] | (grant_q[m][s] & m_ready_i[m]);
         end
      end
   end

endmodule

// File: tb/tb_xbar_arbiter.sv
// Directed bench for xbar_arbiter (2 sources, 3 destinations); inputs change 1ns
// after each rising edge and outputs are compared at that same point.
module tb_xbar_arbiter;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [3:0] s_dest_i;
   logic [1:0] s_valid_i;
   logic [1:0] s_last_i;
   logic [1:0] s_ready_o;
   logic [2:0] m_ready_i;
   logic [5:0] req_o;
   logic [2:0] busy_o;

   int n_checks = 0;
   int n_errors = 0;

   xbar_arbiter #(.S_DATA_COUNT(2), .M_DATA_COUNT(3)) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .s_dest_i  (s_dest_i),
      .s_valid_i (s_valid_i),
      .s_last_i  (s_last_i),
      .s_ready_o (s_ready_o),
      .m_ready_i (m_ready_i),
      .req_o     (req_o),
      .busy_o    (busy_o)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // s_dest_i = {s1_dest, s0_dest}; req_o = {row2, row1, row0}, each row = {s1, s0}
      rst_i = 1'b1; s_dest_i = 4'b0000; s_valid_i = 2'b00; s_last_i = 2'b00; m_ready_i = 3'b111;
      cyc(); cyc();
      rst_i = 1'b0;
      check("reset_req", req_o, 6'b000000);
      check("reset_busy", busy_o, 3'b000);
      check("reset_ready", s_ready_o, 2'b00);

      // s0 -> dest 1, granted one cycle later
      s_dest_i = 4'b0001; s_valid_i = 2'b01;
      cyc();
      check("grant_d1_req", req_o, 6'b000100);
      check("grant_d1_busy", busy_o, 3'b010);
      check("grant_d1_ready", s_ready_o, 2'b01);
      m_ready_i = 3'b101;
      #1;
      check("ready_follows_m", s_ready_o, 2'b00);

      // valid drops mid-packet with m_ready toggling; grant is held
      for (int i = 0; i < 3; i++) begin
         s_valid_i = 2'b00; s_last_i = 2'b01;
         m_ready_i = (i % 2 == 0) ? 3'b111 : 3'b101;
         cyc();
         check("hold_req", req_o, 6'b000100);
         check("hold_busy", busy_o, 3'b010);
      end
      s_valid_i = 2'b01; s_last_i = 2'b01; m_ready_i = 3'b101;
      cyc();
      check("hold_no_ready", req_o, 6'b000100);
      m_ready_i = 3'b111;
      cyc();
      check("release_d1_req", req_o, 6'b000000);
      check("release_d1_busy", busy_o, 3'b000);
      s_valid_i = 2'b00; s_last_i = 2'b00;
      cyc();
      check("idle_after_d1", req_o, 6'b000000);

      // both sources -> dest 2, 3-beat packets
      s_dest_i = 4'b1010; s_valid_i = 2'b11;
      cyc();
      check("rr_first_s0", req_o, 6'b010000);
      check("rr_first_ready", s_ready_o, 2'b01);
      cyc(); cyc();
      s_last_i = 2'b01;
      cyc();
      check("bubble_req", req_o, 6'b000000);
      check("bubble_busy", busy_o, 3'b000);
      s_valid_i = 2'b10; s_last_i = 2'b00;
      cyc();
      check("rr_second_s1", req_o, 6'b100000);
      check("rr_second_ready", s_ready_o, 2'b10);
      cyc(); cyc();
      s_last_i = 2'b10;
      cyc();
      check("release_s1_d2", req_o, 6'b000000);
      // pointer wrapped back to 0: s0 wins, then s1 wins while s0 keeps asking
      s_valid_i = 2'b11; s_last_i = 2'b00;
      cyc();
      check("rr_wrap_s0", req_o, 6'b010000);
      s_last_i = 2'b01;
      cyc();
      check("release_s0_again", req_o, 6'b000000);
      s_last_i = 2'b00;
      cyc();
      check("rr_fair_s1", req_o, 6'b100000);
      s_last_i = 2'b10;
      cyc();
      check("release_s1_again", req_o, 6'b000000);
      s_valid_i = 2'b00; s_last_i = 2'b00;
      cyc();

      // simultaneous grants on different destinations, single-beat packets
      s_dest_i = 4'b1000; s_valid_i = 2'b11;
      cyc();
      check("dual_req", req_o, 6'b100001);
      check("dual_busy", busy_o, 3'b101);
      check("dual_ready", s_ready_o, 2'b11);
      s_last_i = 2'b11;
      cyc();
      check("dual_release", req_o, 6'b000000);
      s_valid_i = 2'b00; s_last_i = 2'b00;
      cyc();

      // out-of-range destination is never granted
      s_dest_i = 4'b1100; s_valid_i = 2'b10;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("bad_dest_req", req_o, 6'b000000);
         check("bad_dest_ready", s_ready_o, 2'b00);
      end

      // reset mid-packet on dest 0 (rr_ptr[0] is 1 here), then pointer restarts at 0
      s_valid_i = 2'b11;
      cyc();
      check("pre_reset_grant", req_o, 6'b000001);
      check("pre_reset_ready", s_ready_o, 2'b01);
      cyc();
      s_dest_i = 4'b0000; rst_i = 1'b1;
      cyc();
      check("midrst_req", req_o, 6'b000000);
      check("midrst_ready", s_ready_o, 2'b00);
      check("midrst_busy", busy_o, 3'b000);
      rst_i = 1'b0;
      cyc();
      check("post_rst_ptr0", req_o, 6'b000001);
      s_last_i = 2'b01;
      cyc();
      check("post_rst_release", req_o, 6'b000000);
      s_valid_i = 2'b00; s_last_i = 2'b00;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
